// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes, FSM states,
// instruction classes and datapath mux encodings.
package mc_ctrl_pkg;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_MUL  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6,
        S_ERR  = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        CL_ARITH     = 4'd0,
        CL_ARITH_IMM = 4'd1,
        CL_LOAD      = 4'd2,
        CL_STORE     = 4'd3,
        CL_JAL       = 4'd4,
        CL_JALR      = 4'd5,
        CL_BRANCH    = 4'd6,
        CL_ECALL     = 4'd7,
        CL_ILLEGAL   = 4'd8
    } op_class_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_ALU    = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        ALU_B_RS2  = 2'd0,
        ALU_B_IMM  = 2'd1,
        ALU_B_FOUR = 2'd2
    } alu_b_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_IMEM    = 2'd1,
        ERR_DMEM    = 2'd2,
        ERR_ILLEGAL = 2'd3
    } err_e;

endpackage

// File: rtl/multicycle_control_fsm_decode.sv
// mc_decode: combinational opcode-to-class mapping used by the control FSM in ID.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class
);

    always_comb begin
        op_class = CL_ILLEGAL;
        case (opcode)
            OP_ARITH:     op_class = CL_ARITH;
            OP_ARITH_IMM: op_class = CL_ARITH_IMM;
            OP_LOAD:      op_class = CL_LOAD;
            OP_STORE:     op_class = CL_STORE;
            OP_JAL:       op_class = CL_JAL;
            OP_JALR:      op_class = CL_JALR;
            OP_BRANCH:    op_class = CL_BRANCH;
            OP_ECALL:     op_class = CL_ECALL;
            default:      op_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/MEM/MUL/WB/HALT/ERR) with cache-ready timeouts.
// Optional M-extension sequencing through the MUL state when RV32M_EN is defined.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       funct7_0,
    input  logic       bcond,
    input  logic       halt_cond,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       mul_start,
    output logic       halted,
    output logic [1:0] err_code,
    output logic [2:0] state
);

    // The wait counter saturates at 255, so larger timeouts collapse onto that value.
    localparam logic [7:0] TIMEOUT_CNT = (MEM_TIMEOUT > 255) ? 8'd255 : 8'(MEM_TIMEOUT);
    localparam bit         TIMEOUT_EN  = (MEM_TIMEOUT != 0);

    state_e    state_q, state_d;
    op_class_e class_q;
    op_class_e dec_class;
    err_e      err_q, err_d;
    logic [7:0] wait_cnt;
    logic       timeout_hit;

`ifdef RV32M_EN
    localparam logic [7:0] MUL_LAST = 8'(MUL_LATENCY - 1);
    logic       mul_q;
    logic [7:0] mul_cnt;
`else
    logic unused_rv32m;
    assign unused_rv32m = funct7_0 | (MUL_LATENCY == 0);
`endif

    mc_decode u_decode (
        .opcode   (opcode),
        .op_class (dec_class)
    );

    assign timeout_hit = TIMEOUT_EN && (wait_cnt == TIMEOUT_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IF;
            class_q  <= CL_ARITH;
            err_q    <= ERR_NONE;
            wait_cnt <= '0;
`ifdef RV32M_EN
            mul_q    <= 1'b0;
            mul_cnt  <= '0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == S_ID) begin
                class_q <= dec_class;
`ifdef RV32M_EN
                mul_q   <= funct7_0 && (dec_class == CL_ARITH);
`endif
            end
            // Any state change clears the counter, so it is zero on entry to IF or MEM.
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if ((state_q == S_IF || state_q == S_MEM) && wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
`ifdef RV32M_EN
            if (state_q == S_MUL) begin
                mul_cnt <= mul_cnt + 8'd1;
            end else begin
                mul_cnt <= '0;
            end
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_PLUS4;
        alu_src_a = 1'b0;
        alu_src_b = ALU_B_RS2;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        mul_start = 1'b0;

        case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_ID;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                    err_d   = ERR_IMEM;
                end
            end

            // ID works on the live decode; everything after uses the latched class.
            S_ID: begin
                case (dec_class)
                    CL_ECALL: begin
                        if (halt_cond) begin
                            state_d = S_HALT;
                        end else begin
                            pc_write = 1'b1;
                            pc_src   = PC_PLUS4;
                            state_d  = S_IF;
                        end
                    end
                    CL_ILLEGAL: begin
                        state_d = S_ERR;
                        err_d   = ERR_ILLEGAL;
                    end
                    default: state_d = S_EX;
                endcase
            end

            S_EX: begin
                alu_src_a = (class_q != CL_JAL);
                case (class_q)
                    CL_ARITH, CL_BRANCH: alu_src_b = ALU_B_RS2;
                    CL_JAL:              alu_src_b = ALU_B_FOUR;
                    default:             alu_src_b = ALU_B_IMM;
                endcase
                case (class_q)
                    CL_LOAD, CL_STORE: state_d = S_MEM;
                    CL_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = bcond ? PC_BRANCH : PC_PLUS4;
                        state_d  = S_IF;
                    end
                    default: begin
`ifdef RV32M_EN
                        if (mul_q) begin
                            mul_start = 1'b1;
                            state_d   = S_MUL;
                        end else begin
                            state_d = S_WB;
                        end
`else
                        state_d = S_WB;
`endif
                    end
                endcase
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (class_q == CL_STORE);
                if (dmem_ready) begin
                    if (class_q == CL_STORE) begin
                        pc_write = 1'b1;
                        pc_src   = PC_PLUS4;
                        state_d  = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                    err_d   = ERR_DMEM;
                end
            end

`ifdef RV32M_EN
            S_MUL: begin
                if (mul_cnt == MUL_LAST) begin
                    state_d = S_WB;
                end
            end
`endif

            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                case (class_q)
                    CL_LOAD: wb_sel = WB_MEM;
                    CL_JAL: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_BRANCH;
                    end
                    CL_JALR: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_ALU;
                    end
                    default: wb_sel = WB_ALU;
                endcase
                state_d = S_IF;
            end

            S_HALT, S_ERR: state_d = state_q;

            default: state_d = S_IF;
        endcase
    end

    assign halted   = (state_q == S_HALT);
    assign err_code = err_q;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: spec cycle-count table, corner sequences,
// and randomized instruction streams checked against a per-instruction trace model.
module tb_multicycle_control_fsm;

    localparam int unsigned T = 4;
    localparam int unsigned L = 2;
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [6:0] O_R   = 7'b0110011;
    localparam logic [6:0] O_I   = 7'b0010011;
    localparam logic [6:0] O_LD  = 7'b0000011;
    localparam logic [6:0] O_ST  = 7'b0100011;
    localparam logic [6:0] O_JAL = 7'b1101111;
    localparam logic [6:0] O_JR  = 7'b1100111;
    localparam logic [6:0] O_BR  = 7'b1100011;
    localparam logic [6:0] O_EC  = 7'b1110011;
    localparam logic [6:0] O_LUI = 7'b0110111;

    localparam logic [2:0] Q_IF = 3'd0, Q_ID = 3'd1, Q_EX = 3'd2, Q_MEM = 3'd3;
    localparam logic [2:0] Q_MUL = 3'd4, Q_WB = 3'd5, Q_HALT = 3'd6, Q_ERR = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       funct7_0, bcond, halt_cond, imem_ready, dmem_ready;
    logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, alu_src_a;
    logic       reg_write, mul_start, halted;
    logic [1:0] pc_src, alu_src_b, wb_sel, err_code;
    logic [2:0] state;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_TIMEOUT(T), .MUL_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct7_0(funct7_0),
        .bcond(bcond), .halt_cond(halt_cond), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .wb_sel(wb_sel), .mul_start(mul_start),
        .halted(halted), .err_code(err_code), .state(state)
    );

    typedef struct packed {
        logic       imem_req, dmem_req, dmem_we, ir_write, pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       mul_start, halted;
        logic [1:0] err_code;
        logic [2:0] state;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic       f7, bc, hc, ri, rd, rst;
        out_t       exp;
    } cyc_t;

    typedef struct {
        logic [6:0]  op;
        logic        f7, bc, hc;
        int unsigned di, dm;
        int unsigned exp_cyc, exp_rw;
        logic [1:0]  exp_ps;
    } vec_t;

    out_t act;
    assign act = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, reg_write, wb_sel, mul_start, halted, err_code, state};

    int n_cmp = 0;
    int n_bad = 0;
    cyc_t q[$];
    logic [6:0] cur_op;
    logic cur_f7, cur_bc, cur_hc;

    task automatic check_out(input string name, input out_t a, input out_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s #%0d: got %h want %h (state got %0d want %0d)",
                     name, n_cmp, a, e, a.state, e.state);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s #%0d: got %0d want %0d", name, n_cmp, a, e);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic out_t st(input logic [2:0] s);
        out_t o;
        o = '0;
        o.state = s;
        return o;
    endfunction

    function automatic void push(input logic ri, input logic rd, input logic rst, input out_t e);
        cyc_t c;
        c.op = cur_op; c.f7 = cur_f7; c.bc = cur_bc; c.hc = cur_hc;
        c.ri = ri; c.rd = rd; c.rst = rst; c.exp = e;
        q.push_back(c);
    endfunction

    // Absorbing HALT/ERR: a few idle cycles with random readies, then one reset cycle.
    function automatic void absorb(input logic [2:0] s, input logic [1:0] ec);
        out_t o;
        o = st(s);
        o.halted = (s == Q_HALT);
        o.err_code = ec;
        for (int i = 0; i < 3; i++) push(rb(), rb(), 1'b0, o);
        push(rb(), rb(), 1'b1, o);
    endfunction

    // Expected per-cycle trace of one instruction, built phase by phase from the rules.
    function automatic void gen(input logic [6:0] op, input logic f7, input logic bc,
                                input logic hc, input int unsigned di, input int unsigned dm);
        out_t o;
        bit r, i, ld, sv, jal, jr, br, ec, mul;
        cur_op = op; cur_f7 = f7; cur_bc = bc; cur_hc = hc;
        r = (op == O_R); i = (op == O_I); ld = (op == O_LD); sv = (op == O_ST);
        jal = (op == O_JAL); jr = (op == O_JR); br = (op == O_BR); ec = (op == O_EC);
        mul = M_EN && r && f7;

        for (int unsigned k = 0; k < di; k++) begin
            o = st(Q_IF); o.imem_req = 1'b1;
            push(1'b0, rb(), 1'b0, o);
            if (T != 0 && k == T) begin absorb(Q_ERR, 2'd1); return; end
        end
        o = st(Q_IF); o.imem_req = 1'b1; o.ir_write = 1'b1;
        push(1'b1, rb(), 1'b0, o);

        o = st(Q_ID);
        if (ec) begin
            if (hc) begin push(rb(), rb(), 1'b0, o); absorb(Q_HALT, 2'd0); return; end
            o.pc_write = 1'b1;
            push(rb(), rb(), 1'b0, o);
            return;
        end
        push(rb(), rb(), 1'b0, o);
        if (!(r || i || ld || sv || jal || jr || br)) begin absorb(Q_ERR, 2'd3); return; end

        o = st(Q_EX);
        o.alu_src_a = !jal;
        o.alu_src_b = (r || br) ? 2'd0 : (jal ? 2'd2 : 2'd1);
        if (br) begin
            o.pc_write = 1'b1;
            o.pc_src = bc ? 2'd1 : 2'd0;
            push(rb(), rb(), 1'b0, o);
            return;
        end
        o.mul_start = mul;
        push(rb(), rb(), 1'b0, o);

        if (ld || sv) begin
            for (int unsigned k = 0; k < dm; k++) begin
                o = st(Q_MEM); o.dmem_req = 1'b1; o.dmem_we = sv;
                push(rb(), 1'b0, 1'b0, o);
                if (T != 0 && k == T) begin absorb(Q_ERR, 2'd2); return; end
            end
            o = st(Q_MEM); o.dmem_req = 1'b1; o.dmem_we = sv; o.pc_write = sv;
            push(rb(), 1'b1, 1'b0, o);
            if (sv) return;
        end

        if (mul) for (int unsigned k = 0; k < L; k++) push(rb(), rb(), 1'b0, st(Q_MUL));

        o = st(Q_WB);
        o.reg_write = 1'b1;
        o.pc_write = 1'b1;
        o.wb_sel = ld ? 2'd1 : ((jal || jr) ? 2'd2 : 2'd0);
        o.pc_src = jal ? 2'd1 : (jr ? 2'd2 : 2'd0);
        push(rb(), rb(), 1'b0, o);
    endfunction

    task automatic drain();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            opcode = c.op; funct7_0 = c.f7; bcond = c.bc; halt_cond = c.hc;
            imem_ready = c.ri; dmem_ready = c.rd; reset = c.rst;
            #1;
            check_out("trace", act, c.exp);
        end
    endtask

    // Runs one instruction with ready delays, measuring length up to its pc_write pulse.
    task automatic run_vec(input vec_t v);
        int unsigned cyc, rw, fi, fm;
        logic [1:0] ps;
        bit seen;
        cyc = 0; rw = 0; fi = 0; fm = 0; ps = 2'd3; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            reset = 1'b0;
            opcode = v.op; funct7_0 = v.f7; bcond = v.bc; halt_cond = v.hc;
            imem_ready = (state == Q_IF) && (fi == v.di);
            dmem_ready = (state == Q_MEM) && (fm == v.dm);
            #1;
            cyc++;
            if (reg_write) rw++;
            if (pc_write) begin seen = 1'b1; ps = pc_src; end
            if (state == Q_IF) fi++;
            if (state == Q_MEM) fm++;
        end
        check_int("cycles", int'(cyc), int'(v.exp_cyc));
        check_int("reg_writes", int'(rw), int'(v.exp_rw));
        check_int("pc_src", int'(ps), int'(v.exp_ps));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t  vt[10];
        out_t  rexp;
        logic [6:0] ops[10];
        logic [6:0] op;
        int unsigned di, dm;

        vt[0] = '{O_R,   1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 2'd0};
        vt[1] = '{O_LD,  1'b0, 1'b0, 1'b0, 0, 3, 8, 1, 2'd0};
        vt[2] = '{O_BR,  1'b0, 1'b1, 1'b0, 0, 0, 3, 0, 2'd1};
        vt[3] = '{O_BR,  1'b0, 1'b0, 1'b0, 2, 0, 5, 0, 2'd0};
        vt[4] = '{O_ST,  1'b0, 1'b0, 1'b0, 0, 1, 5, 0, 2'd0};
        vt[5] = '{O_JAL, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 2'd1};
        vt[6] = '{O_JR,  1'b0, 1'b0, 1'b0, 1, 0, 5, 1, 2'd2};
        vt[7] = '{O_I,   1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 2'd0};
        vt[8] = '{O_EC,  1'b0, 1'b0, 1'b0, 0, 0, 2, 0, 2'd0};
        vt[9] = '{O_R,   1'b1, 1'b0, 1'b0, 0, 0, M_EN ? 4 + L : 4, 1, 2'd0};

        reset = 1'b1; opcode = '0; funct7_0 = 1'b0; bcond = 1'b0; halt_cond = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        rexp = st(Q_IF); rexp.imem_req = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            check_out("reset", act, rexp);
        end

        for (int i = 0; i < 10; i++) run_vec(vt[i]);

        // Corner sequences: illegal, timeout boundaries, halt with reset.
        gen(O_LUI, 1'b0, 1'b0, 1'b0, 0, 0);
        gen(O_R,   1'b0, 1'b0, 1'b0, T + 1, 0);
        gen(O_LD,  1'b0, 1'b0, 1'b0, T, T);
        gen(O_ST,  1'b0, 1'b0, 1'b0, 0, T + 1);
        gen(O_EC,  1'b0, 1'b0, 1'b1, 1, 0);
        gen(O_R,   1'b1, 1'b0, 1'b0, 0, 0);
        drain();

        ops = '{O_R, O_I, O_LD, O_ST, O_JAL, O_JR, O_BR, O_EC, O_LUI, O_R};
        for (int n = 0; n < 150; n++) begin
            op = ops[$urandom_range(0, 9)];
            if (op == O_LUI && rb()) op = O_I;
            di = ($urandom_range(0, 15) == 0) ? $urandom_range(T, T + 2) : $urandom_range(0, 3);
            dm = ($urandom_range(0, 15) == 0) ? $urandom_range(T, T + 2) : $urandom_range(0, 3);
            gen(op, rb(), rb(), ($urandom_range(0, 3) == 0), di, dm);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
